// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared types and helpers for the clock divider bank
package clk_div_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } ch_state_e;

    function automatic int lock_cnt_w(input int periods);
        return $clog2(periods + 1);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one integer divider channel with pending divisor and lock counter
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int               CNT_W        = CNT_W_DEF,
    parameter int               LOCK_PERIODS = 4,
    parameter logic [CNT_W-1:0] DIV_RST      = CNT_W'(2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             align,
    output logic             clk_out,
    output logic             tick,
    output logic             ch_lock,
    output logic             pending,
    output logic             running
);

    localparam int              LK_W    = lock_cnt_w(LOCK_PERIODS);
    localparam logic [LK_W-1:0] PER_MAX = LK_W'(LOCK_PERIODS);
    localparam logic [CNT_W:0]  ONE_X   = (CNT_W+1)'(1);
    localparam ch_state_e       ST_RST  = ((DIV_RST >> 1) != '0) ? ST_RUN : ST_OFF;

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LK_W-1:0]  per_q, per_d, per_inc;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             term;
    logic             run_d;

    // Extended compare keeps N-1 correct for every legal divisor width.
    assign term    = ({1'b0, cnt_q} == ({1'b0, div_q} - ONE_X));
    assign per_inc = (per_q == PER_MAX) ? per_q : per_q + 1'b1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        unique case (state_q)
            ST_OFF: begin
                if (wr_en && ((wr_div >> 1) != '0)) begin
                    state_d = ST_RUN;
                    div_d   = wr_div;
                    cnt_d   = '0;
                    per_d   = '0;
                end
            end
            default: begin
                if (term) per_d = per_inc;
                if (align || term) begin
                    cnt_d = '0;
                    if (state_q == ST_PEND) begin
                        div_d   = pend_q;
                        pend_d  = '0;
                        per_d   = '0;
                        state_d = ((pend_q >> 1) != '0) ? ST_RUN : ST_OFF;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A write on the align edge still lands after the align.
                if (wr_en && state_q == ST_RUN) begin
                    pend_d  = wr_div;
                    state_d = ST_PEND;
                end
            end
        endcase
        run_d  = (state_d != ST_OFF);
        clk_d  = run_d && (cnt_d < (div_d >> 1));
        tick_d = run_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            div_q   <= DIV_RST;
            pend_q  <= '0;
            cnt_q   <= DIV_RST - CNT_W'(1);
            per_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign running = (state_q != ST_OFF);
    assign pending = (state_q == ST_PEND);
    assign ch_lock = running && (per_q == PER_MAX);

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of runtime-programmable integer clock dividers with lock
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int                      NUM_CH       = 4,
    parameter int                      CNT_W        = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT     = {16'd12, 16'd6, 16'd3, 16'd2},
    parameter int                      LOCK_PERIODS = 4,
    localparam int                     CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ready,
    input  logic              align,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] ch_lock,
    output logic              lock
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] running;
    logic [NUM_CH-1:0] wr_en;
    logic              lock_q;

    assign cfg_ready = (int'(cfg_ch) < NUM_CH) ? !pending[cfg_ch] : 1'b1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_en[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        clk_div_chan #(
            .CNT_W        (CNT_W),
            .LOCK_PERIODS (LOCK_PERIODS),
            .DIV_RST      (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[i]),
            .wr_div  (cfg_div),
            .align   (align),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .ch_lock (ch_lock[i]),
            .pending (pending[i]),
            .running (running[i])
        );
    end

    // Stopped channels are excluded; an all-off bank never reports lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= 1'b0;
        else        lock_q <= (|running) && (&(ch_lock | ~running));
    end

    assign lock = lock_q;

endmodule
